// File: rtl/fifo_axis_pkg.sv
// Shared types for the FIFO-to-AXI-Stream drain engine.
package fifo_axis_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int LEN_WIDTH_DEF  = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic [DATA_WIDTH_DEF-1:0] data;
      logic                      last;
   } beat_t;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-Stream skid buffer; upstream ready is a pure register so the
// downstream tready never reaches the producer combinationally.
module axis_skid_buf
   import fifo_axis_pkg::*;
#(
   parameter int W = DATA_WIDTH_DEF + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready
);

   logic [W-1:0] main_data;
   logic         main_valid;
   logic [W-1:0] skid_data;
   logic         skid_valid;
   logic         main_free;

   // Main can accept a word when it is empty or its current word leaves now.
   assign main_free = !main_valid || out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_data  <= '0;
         main_valid <= 1'b0;
         skid_data  <= '0;
         skid_valid <= 1'b0;
      end else begin
         if (main_free) begin
            if (skid_valid) begin
               main_data  <= skid_data;
               main_valid <= 1'b1;
               skid_valid <= 1'b0;
            end else if (in_valid) begin
               main_data  <= in_data;
               main_valid <= 1'b1;
            end else begin
               main_valid <= 1'b0;
            end
         end else if (in_valid) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
         end
      end
   end

   assign in_ready  = !skid_valid;
   assign out_data  = main_data;
   assign out_valid = main_valid;

endmodule

// File: rtl/fifo_axis_tx.sv
// Drains a first-word-fall-through FIFO into an AXI-Stream master, framing
// cfg_len beats per packet with tlast on the final beat.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | popping words until the tagged last word is popped
// FLUSH | waiting for the last beat to handshake downstream
// DONE  | one-cycle done pulse
module fifo_axis_tx
   import fifo_axis_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  cfg_len,
   input  logic                  fifo_empty,
   input  logic                  fifo_last,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_rd_en,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tvalid,
   output logic                  m_tlast,
   input  logic                  m_tready,
   output logic                  busy,
   output logic                  done,
   output logic                  underrun
);

   state_t                 state;
   state_t                 state_nxt;
   logic [LEN_WIDTH-1:0]   len_q;
   logic [LEN_WIDTH-1:0]   pop_cnt;
   logic                   fifo_last_q;
   logic                   buf_ready;
   logic                   pop;
   logic                   pop_last;
   logic                   last_hs;
   logic [DATA_WIDTH:0]    buf_out;

   assign pop      = (state == RUN) && !fifo_empty && buf_ready;
   assign pop_last = (pop_cnt == len_q - 1'b1);
   assign last_hs  = m_tvalid && m_tready && m_tlast;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (pop && pop_last) state_nxt = FLUSH;
         FLUSH:   if (last_hs) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A zero length is promoted to a single-beat packet.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         len_q       <= '0;
         pop_cnt     <= '0;
         underrun    <= 1'b0;
         fifo_last_q <= 1'b0;
      end else begin
         fifo_last_q <= fifo_last;
         if (state == IDLE && start) begin
            len_q    <= (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
            pop_cnt  <= '0;
            underrun <= 1'b0;
         end else begin
            if (pop) begin
               pop_cnt <= pop_cnt + 1'b1;
            end
            if (state == RUN && fifo_empty && fifo_last_q) begin
               underrun <= 1'b1;
            end
         end
      end
   end

   axis_skid_buf #(
      .W (DATA_WIDTH + 1)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_data   ({fifo_data, pop_last}),
      .in_valid  (pop),
      .in_ready  (buf_ready),
      .out_data  (buf_out),
      .out_valid (m_tvalid),
      .out_ready (m_tready)
   );

   assign m_tdata    = buf_out[DATA_WIDTH:1];
   assign m_tlast    = buf_out[0];
   assign fifo_rd_en = pop;
   assign busy       = (state != IDLE);
   assign done       = (state == DONE);

endmodule

// File: tb/tb_fifo_axis_tx.sv
// Directed bench for fifo_axis_tx: FWFT FIFO model, scoreboard of expected
// beats, and handshake/hold checks sampled on the falling edge.
module tb_fifo_axis_tx;
   import fifo_axis_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [9:0]  cfg_len;
   logic        fifo_empty;
   logic        fifo_last;
   logic [31:0] fifo_data;
   logic        fifo_rd_en;
   logic [31:0] m_tdata;
   logic        m_tvalid;
   logic        m_tlast;
   logic        m_tready;
   logic        busy;
   logic        done;
   logic        underrun;

   always #5 clk = ~clk;

   fifo_axis_tx dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .cfg_len    (cfg_len),
      .fifo_empty (fifo_empty),
      .fifo_last  (fifo_last),
      .fifo_data  (fifo_data),
      .fifo_rd_en (fifo_rd_en),
      .m_tdata    (m_tdata),
      .m_tvalid   (m_tvalid),
      .m_tlast    (m_tlast),
      .m_tready   (m_tready),
      .busy       (busy),
      .done       (done),
      .underrun   (underrun)
   );

   logic [31:0] mem [0:2047];
   int wr_ptr = 0;
   int rd_ptr = 0;
   int pops   = 0;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_last  = ((wr_ptr - rd_ptr) == 1);
   assign fifo_data  = fifo_empty ? 32'h0 : mem[rd_ptr[10:0]];

   always @(posedge clk) begin
      if (fifo_rd_en) begin
         rd_ptr <= rd_ptr + 1;
         pops   <= pops + 1;
      end
   end

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   beat_t exp_q[$];
   logic [31:0] model_q[$];
   int remaining = 0;
   int pkt_beats, first_edge, last_edge, done_edge, done_cnt, start_edge;
   logic prev_stall = 1'b0;
   logic [31:0] prev_data = '0;
   logic prev_last = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      beat_t e;
      @(negedge clk);
      if (fifo_rd_en) chk("pop_when_empty", fifo_empty, 1'b0);
      if (prev_stall) begin
         chk("hold_valid", m_tvalid, 1'b1);
         chk("hold_data", m_tdata, prev_data);
         chk("hold_last", m_tlast, prev_last);
      end
      if (m_tvalid && m_tready) begin
         chk("beat_expected", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("beat_data", m_tdata, e.data);
            chk("beat_last", m_tlast, e.last);
         end
         if (pkt_beats == 0) first_edge = cyc + 1;
         last_edge = cyc + 1;
         pkt_beats++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
      if (done) begin
         done_cnt++;
         done_edge = cyc + 1;
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic push_word(input logic [31:0] d);
      beat_t e;
      mem[wr_ptr[10:0]] = d;
      wr_ptr++;
      if (remaining > 0) begin
         e.data = d;
         e.last = (remaining == 1);
         exp_q.push_back(e);
         remaining--;
      end else begin
         model_q.push_back(d);
      end
   endtask

   task automatic do_start(input int len);
      beat_t e;
      int l = (len == 0) ? 1 : len;
      pkt_beats = 0; first_edge = -1; last_edge = -1; done_edge = -1; done_cnt = 0;
      remaining = 0;
      for (int i = 0; i < l; i++) begin
         if (model_q.size() > 0) begin
            e.data = model_q.pop_front();
            e.last = (i == l - 1);
            exp_q.push_back(e);
         end else begin
            remaining++;
         end
      end
      start   = 1'b1;
      cfg_len = len[9:0];
      tick();
      start_edge = cyc;
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         tick();
         n++;
      end
      chk("idle_timeout", busy, 1'b0);
      chk("scoreboard_empty", exp_q.size(), 0);
   endtask

   initial begin
      int p0, plast, n;
      rst = 1'b0; start = 1'b0; cfg_len = '0; m_tready = 1'b0;
      repeat (3) tick();
      chk("rst_tvalid", m_tvalid, 1'b0);
      chk("rst_tdata", m_tdata, 32'h0);
      chk("rst_tlast", m_tlast, 1'b0);
      chk("rst_rd_en", fifo_rd_en, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_underrun", underrun, 1'b0);
      rst = 1'b1;
      tick();

      // basic 4-beat packet, full throughput
      push_word(32'h11); push_word(32'h22); push_word(32'h33); push_word(32'h44);
      tick();
      chk("t1_idle_no_pop", pops, 0);
      m_tready = 1'b1;
      do_start(4);
      chk("t1_busy", busy, 1'b1);
      chk("t1_rd_en", fifo_rd_en, 1'b1);
      chk("t1_tvalid_lat", m_tvalid, 1'b0);
      wait_idle(30);
      chk("t1_beats", pkt_beats, 4);
      chk("t1_first_edge", first_edge, start_edge + 2);
      chk("t1_last_edge", last_edge, start_edge + 5);
      chk("t1_done_edge", done_edge, start_edge + 6);
      chk("t1_done_cnt", done_cnt, 1);
      chk("t1_done_low", done, 1'b0);

      // short packet leaves words behind for the next one
      for (int i = 1; i <= 5; i++) push_word(32'hA0 + i);
      p0 = pops;
      do_start(3);
      wait_idle(30);
      chk("t2_pops", pops - p0, 3);
      chk("t2_level", wr_ptr - rd_ptr, 2);
      do_start(2);
      wait_idle(30);
      chk("t2b_beats", pkt_beats, 2);
      chk("t2b_level", wr_ptr - rd_ptr, 0);
      chk("t2b_underrun", underrun, 1'b0);

      // 10-cycle stall mid-packet
      for (int i = 0; i < 8; i++) push_word(32'hB0 + i);
      do_start(8);
      repeat (3) tick();
      m_tready = 1'b0;
      p0 = pops;
      repeat (10) tick();
      chk("t3_stall_pops", (pops - p0) <= 2, 1'b1);
      chk("t3_stall_rd_en", fifo_rd_en, 1'b0);
      m_tready = 1'b1;
      wait_idle(40);
      chk("t3_beats", pkt_beats, 8);

      // alternating ready
      for (int i = 0; i < 6; i++) push_word(32'hBB00 + i);
      do_start(6);
      for (int i = 0; i < 30 && busy; i++) begin
         m_tready = i[0];
         tick();
      end
      m_tready = 1'b1;
      wait_idle(20);
      chk("t3b_beats", pkt_beats, 6);

      // sparse FIFO writes
      do_start(4);
      plast = 0;
      for (int k = 0; k < 4; k++) begin
         push_word(32'hC0 + k);
         plast = cyc;
         repeat (5) tick();
      end
      wait_idle(20);
      chk("t4_beats", pkt_beats, 4);
      chk("t4_resume_edge", last_edge, plast + 2);
      chk("t4_underrun_set", underrun, 1'b1);
      push_word(32'hC9);
      do_start(0);
      chk("t4b_underrun_clr", underrun, 1'b0);
      wait_idle(20);
      chk("t4b_beats", pkt_beats, 1);

      // async reset with both buffer entries full
      for (int i = 1; i <= 4; i++) push_word(32'hD0 + i);
      m_tready = 1'b0;
      do_start(4);
      repeat (4) tick();
      chk("t5_pre_tvalid", m_tvalid, 1'b1);
      chk("t5_pre_tdata", m_tdata, 32'hD1);
      chk("t5_pre_level", wr_ptr - rd_ptr, 2);
      #2 rst = 1'b0;
      #1;
      chk("t5_rst_tvalid", m_tvalid, 1'b0);
      chk("t5_rst_tdata", m_tdata, 32'h0);
      chk("t5_rst_tlast", m_tlast, 1'b0);
      chk("t5_rst_rd_en", fifo_rd_en, 1'b0);
      chk("t5_rst_busy", busy, 1'b0);
      exp_q.delete();
      model_q.delete();
      model_q.push_back(32'hD3);
      model_q.push_back(32'hD4);
      remaining = 0;
      prev_stall = 1'b0;
      tick();
      rst = 1'b1;
      m_tready = 1'b1;
      p0 = pops;
      repeat (5) tick();
      chk("t5_idle_pops", pops - p0, 0);
      chk("t5_idle_tvalid", m_tvalid, 1'b0);
      do_start(2);
      wait_idle(20);
      chk("t5_beats", pkt_beats, 2);

      // start pulses in RUN and DONE are ignored
      push_word(32'hE1); push_word(32'hE2); push_word(32'hE3);
      m_tready = 1'b0;
      do_start(3);
      start = 1'b1; cfg_len = 10'd1;
      tick();
      start = 1'b0;
      m_tready = 1'b1;
      n = 0;
      while (!done && n < 40) begin
         tick();
         n++;
      end
      chk("t6_done_seen", done, 1'b1);
      push_word(32'hEE);
      start = 1'b1; cfg_len = 10'd1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      chk("t6_beats", pkt_beats, 3);
      chk("t6_done_cnt", done_cnt, 1);
      chk("t6_busy", busy, 1'b0);
      chk("t6_level", wr_ptr - rd_ptr, 1);
      do_start(1);
      wait_idle(20);
      chk("t6b_beats", pkt_beats, 1);

      // maximum length packet
      for (int i = 0; i < 1023; i++) push_word(32'h1000 + i);
      p0 = pops;
      do_start(1023);
      wait_idle(1200);
      chk("t7_beats", pkt_beats, 1023);
      chk("t7_pops", pops - p0, 1023);
      chk("t7_first_edge", first_edge, start_edge + 2);
      chk("t7_last_edge", last_edge, start_edge + 1024);
      chk("t7_done_edge", done_edge, start_edge + 1025);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
